// File: rtl/dna_port_ctrl.sv
// dna_port_ctrl: drives the device DNA_PORT primitive. It pulses READ for one
// port period, then shifts DNA_WIDTH bits out MSB first on a divided port
// clock, and publishes the ID as a parallel word with a sticky valid flag.
module dna_port_ctrl #(
   parameter int DNA_WIDTH     = 57,
   parameter int CLK_DIV       = 4,
   parameter bit READ_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 dna_valid_o,
   output logic [DNA_WIDTH-1:0] dna_o,
   output logic                 dna_clk_o,
   output logic                 dna_read_o,
   output logic                 dna_shift_o,
   input  logic                 dna_dout_i
);

   // The divider counter is 8 bits wide and each half period must span at
   // least two clk cycles, so reject any other divide ratio at elaboration.
   if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("dna_port_ctrl: CLK_DIV must be in the range 2..255");
   end
   if (DNA_WIDTH < 2) begin : g_bad_dna_width
      $error("dna_port_ctrl: DNA_WIDTH must be at least 2");
   end

   localparam int                 CNT_W    = $clog2(DNA_WIDTH + 1);
   localparam logic [7:0]         DIV_MAX  = 8'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(DNA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   first_cycle;
   logic                   auto_start;
   logic                   accept;
   logic                   capture;
   logic                   div_wrap;
   logic [7:0]             div_cnt;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DNA_WIDTH-1:0]   shreg;

   // Self-start fires only once, in the first clk cycle after reset release.
   assign auto_start = READ_ON_RESET && first_cycle;
   // The divider wraps at the end of every half period of the port clock.
   assign div_wrap   = (div_cnt == DIV_MAX);

   // Next-state decode: sequence IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i || auto_start) begin
               state_next = LOAD;
               accept     = 1'b1;
            end
         end
         LOAD: begin
            // One full port period: low phase then high phase.
            if (div_wrap && dna_clk_o) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Capture on the cycle the port clock is driven 0 -> 1, using the
            // DOUT value from before that rising edge.
            capture = div_wrap && !dna_clk_o;
            // Leave only once the port clock is back low after the last bit.
            if (div_wrap && dna_clk_o && (bit_cnt == BIT_LAST)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus registered status and port control outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state       <= IDLE;
         first_cycle <= 1'b1;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         dna_read_o  <= 1'b0;
         dna_shift_o <= 1'b0;
      end else begin
         state       <= state_next;
         first_cycle <= 1'b0;
         busy_o      <= (state_next != IDLE);
         done_o      <= (state_next == DONE);
         dna_read_o  <= (state_next == LOAD);
         dna_shift_o <= (state_next == SHIFT);
      end
   end

   // Port clock divider: runs only in LOAD/SHIFT, parked low elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         dna_clk_o <= 1'b0;
      end else if (state == LOAD || state == SHIFT) begin
         if (div_wrap) begin
            div_cnt   <= '0;
            dna_clk_o <= ~dna_clk_o;
         end else begin
            div_cnt   <= div_cnt + 8'd1;
         end
      end else begin
         div_cnt   <= '0;
         dna_clk_o <= 1'b0;
      end
   end

   // Shift register, bit counter and the published ID with its valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         dna_o       <= '0;
         dna_valid_o <= 1'b0;
      end else begin
         if (accept) begin
            bit_cnt     <= '0;
            dna_valid_o <= 1'b0;
         end else if (capture) begin
            shreg   <= {shreg[DNA_WIDTH-2:0], dna_dout_i};
            bit_cnt <= bit_cnt + 1'b1;
         end
         // Publish together with the done pulse so done_o and dna_o agree.
         if (state == SHIFT && state_next == DONE) begin
            dna_o       <= shreg;
            dna_valid_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dna_port_ctrl.sv
// tb_dna_port_ctrl: two controllers share one clock. dut_a uses CLK_DIV=4 with
// self-start, dut_b uses CLK_DIV=2 without it. Each has a behavioural DNA_PORT
// model. Stimulus pushes expected IDs into per-DUT queues; a negedge monitor
// pops and compares on every done_o and also checks the port waveform.
`timescale 1ns/1ps
module tb_dna_port_ctrl;
   localparam int           W       = 57;
   localparam logic [W-1:0] ID_A1   = 57'h1A5_5A5A_5A5A_5A5A;
   localparam logic [W-1:0] ID_A2   = 57'h0F0_F0F0_1234_5678;
   localparam logic [W-1:0] ID_ONES = {W{1'b1}};
   localparam logic [W-1:0] ID_ALT  = 57'h155_5555_5555_5555;

   logic         clk = 1'b0;
   logic         rst_a, rst_b, start_a, start_b;
   logic         busy[2], done[2], valid[2], dclk[2], rd[2], sh[2], dout[2];
   logic [W-1:0] dna[2];
   logic [W-1:0] id_a, id_b, msr_a, msr_b;
   logic [W-1:0] exp_a[$];
   logic [W-1:0] exp_b[$];

   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   int   busy_cyc[2], rd_cyc[2], rd_rise[2], sh_rise[2], ovl[2];
   logic busy_d[2] = '{1'b0, 1'b0};
   logic dclk_d[2] = '{1'b0, 1'b0};
   logic done_d[2] = '{1'b0, 1'b0};
   // Hand-derived: done follows busy by 2*CLK_DIV*(57+1); READ lasts 2*CLK_DIV.
   int   lat_exp[2] = '{464, 232};
   int   rd_exp[2]  = '{8, 4};
   int   mon_sz;
   logic [W-1:0] mon_e;

   always #5 clk = ~clk;

   dna_port_ctrl #(.DNA_WIDTH(57), .CLK_DIV(4), .READ_ON_RESET(1'b1)) dut_a (
      .clk(clk), .rst(rst_a), .start_i(start_a),
      .busy_o(busy[0]), .done_o(done[0]), .dna_valid_o(valid[0]), .dna_o(dna[0]),
      .dna_clk_o(dclk[0]), .dna_read_o(rd[0]), .dna_shift_o(sh[0]),
      .dna_dout_i(dout[0])
   );

   dna_port_ctrl #(.DNA_WIDTH(57), .CLK_DIV(2), .READ_ON_RESET(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .start_i(start_b),
      .busy_o(busy[1]), .done_o(done[1]), .dna_valid_o(valid[1]), .dna_o(dna[1]),
      .dna_clk_o(dclk[1]), .dna_read_o(rd[1]), .dna_shift_o(sh[1]),
      .dna_dout_i(dout[1])
   );

   // DNA_PORT models: READ on a rising port clock loads the ID, SHIFT moves
   // the next bit onto DOUT; DOUT always shows the current MSB.
   always @(posedge dclk[0]) begin
      if (rd[0])      msr_a = id_a;
      else if (sh[0]) msr_a = msr_a << 1;
   end
   always @(posedge dclk[1]) begin
      if (rd[1])      msr_b = id_b;
      else if (sh[1]) msr_b = msr_b << 1;
   end
   assign dout[0] = msr_a[W-1];
   assign dout[1] = msr_b[W-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Returns on the negedge of the done_o cycle, or after the cycle budget.
   task automatic wait_done(input int i, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[i] && n < budget);
      check($sformatf("dut%0d done within %0d cycles", i, budget), 64'(done[i]), 64'd1);
   endtask

   // Monitor: port waveform bookkeeping and scoreboard compare on done_o.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (busy[i] && !busy_d[i]) begin
            busy_cyc[i] = cyc;
            rd_cyc[i]   = 0;
            rd_rise[i]  = 0;
            sh_rise[i]  = 0;
            ovl[i]      = 0;
         end
         if (rd[i]) rd_cyc[i]++;
         if (dclk[i] && !dclk_d[i]) begin
            if (rd[i]) rd_rise[i]++;
            if (sh[i]) sh_rise[i]++;
         end
         if (rd[i] && sh[i]) ovl[i]++;
         if (done_d[i]) begin
            check($sformatf("dut%0d done one cycle", i), 64'(done[i]), 64'd0);
            check($sformatf("dut%0d busy low after done", i), 64'(busy[i]), 64'd0);
         end
         if (done[i]) begin
            mon_sz = (i == 0) ? exp_a.size() : exp_b.size();
            check($sformatf("dut%0d done expected", i), 64'(mon_sz != 0), 64'd1);
            if (mon_sz != 0) begin
               if (i == 0) mon_e = exp_a.pop_front();
               else        mon_e = exp_b.pop_front();
               check($sformatf("dut%0d dna_o", i), 64'(dna[i]), 64'(mon_e));
               check($sformatf("dut%0d valid at done", i), 64'(valid[i]), 64'd1);
               check($sformatf("dut%0d latency", i), 64'(cyc - busy_cyc[i]), 64'(lat_exp[i]));
               check($sformatf("dut%0d read cycles", i), 64'(rd_cyc[i]), 64'(rd_exp[i]));
               check($sformatf("dut%0d read rises", i), 64'(rd_rise[i]), 64'd1);
               check($sformatf("dut%0d shift rises", i), 64'(sh_rise[i]), 64'd57);
               check($sformatf("dut%0d read/shift overlap", i), 64'(ovl[i]), 64'd0);
            end
         end
         busy_d[i] = busy[i];
         dclk_d[i] = dclk[i];
         done_d[i] = done[i];
      end
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      id_a = ID_A1; id_b = ID_ONES;
      repeat (3) @(negedge clk);
      check("a reset ctl", 64'({busy[0], done[0], valid[0], dclk[0], rd[0], sh[0]}), 64'd0);
      check("a reset dna", 64'(dna[0]), 64'd0);
      check("b reset ctl", 64'({busy[1], done[1], valid[1], dclk[1], rd[1], sh[1]}), 64'd0);

      // Self-start after reset release on dut_a; dut_b stays idle.
      exp_a.push_back(ID_A1);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("a auto start busy", 64'(busy[0]), 64'd1);
      check("b no auto start", 64'(busy[1]), 64'd0);
      wait_done(0, 600);

      // New read: valid clears, old ID held, mid-read start ignored.
      @(negedge clk);
      id_a = ID_A2; start_a = 1'b1; exp_a.push_back(ID_A2);
      @(negedge clk);
      start_a = 1'b0;
      check("a valid cleared", 64'(valid[0]), 64'd0);
      check("a busy after start", 64'(busy[0]), 64'd1);
      check("a dna held early", 64'(dna[0]), 64'(ID_A1));
      repeat (99) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("a busy during ignored start", 64'(busy[0]), 64'd1);
      repeat (200) @(negedge clk);
      check("a dna held late", 64'(dna[0]), 64'(ID_A1));
      wait_done(0, 600);
      repeat (2) @(negedge clk);
      check("a start not queued", 64'(busy[0]), 64'd0);

      // Abort with reset 200 cycles into a read; no done may follow.
      id_a = ID_A1; start_a = 1'b1; exp_a.push_back(ID_A1);
      @(negedge clk);
      start_a = 1'b0;
      repeat (198) @(negedge clk);
      #2 rst_a = 1'b1;
      exp_a.delete();
      #1;
      check("a abort ctl", 64'({busy[0], done[0], valid[0], dclk[0], rd[0], sh[0]}), 64'd0);
      check("a abort dna", 64'(dna[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      // Release self-starts the next read, which must complete normally.
      exp_a.push_back(ID_A1);
      rst_a = 1'b0;
      wait_done(0, 600);

      // Start during the done cycle is ignored; one cycle later it is taken.
      start_a = 1'b1;
      @(negedge clk);
      check("a start in done ignored", 64'(busy[0]), 64'd0);
      exp_a.push_back(ID_A1);
      @(negedge clk);
      start_a = 1'b0;
      check("a start after done accepted", 64'(busy[0]), 64'd1);
      wait_done(0, 600);

      // dut_b: CLK_DIV=2, all-ones then alternating 1/0.
      @(negedge clk);
      start_b = 1'b1; exp_b.push_back(ID_ONES);
      @(negedge clk);
      start_b = 1'b0;
      check("b busy after start", 64'(busy[1]), 64'd1);
      wait_done(1, 300);
      @(negedge clk);
      id_b = ID_ALT; start_b = 1'b1; exp_b.push_back(ID_ALT);
      @(negedge clk);
      start_b = 1'b0;
      check("b valid cleared", 64'(valid[1]), 64'd0);
      check("b dna held", 64'(dna[1]), 64'(ID_ONES));
      wait_done(1, 300);

      repeat (3) @(negedge clk);
      check("a queue drained", 64'(exp_a.size()), 64'd0);
      check("b queue drained", 64'(exp_b.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dna_port_ctrl.md
Name: dna_port_ctrl

Overview:
- Sequences the device DNA_PORT primitive: issues the READ load, then shifts out the full DNA word serially and presents it as a parallel register with a valid flag.
- Single clock domain; generates the slow DNA port clock internally as a divided strobe.
- Sits between the control/slow-control request logic and the DNA_PORT primitive. Software or an FSM pulses start, then reads back the ID.

Parameters:
- DNA_WIDTH, 57, number of DNA bits shifted out, MSB first.
- CLK_DIV, 4, `clk` cycles per half-period of `dna_clk_o`. Legal range is 2..255; elaboration error outside this range.
- READ_ON_RESET, 1, when 1 the block starts a read automatically on the first cycle after reset deassertion.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  read request, single-cycle pulse or level; sampled only in IDLE
- busy_o  out  1  high while a read sequence is in progress
- done_o  out  1  one-cycle pulse when `dna_o` is updated
- dna_valid_o  out  1  sticky, high once `dna_o` holds a complete ID; cleared at the next accepted start
- dna_o  out  DNA_WIDTH  captured DNA; bit DNA_WIDTH-1 is the first bit shifted out
- dna_clk_o  out  1  to DNA_PORT CLK
- dna_read_o  out  1  to DNA_PORT READ
- dna_shift_o  out  1  to DNA_PORT SHIFT
- dna_dout_i  in  1  from DNA_PORT DOUT

Behaviour:
- Reset:
  - All outputs are 0 and `dna_o` = 0.
  - State = IDLE; divider and bit counter = 0.
  - Asserting `rst` mid-sequence aborts immediately; no `done_o` is produced for the aborted read.
- Divider:
  - Counts 0..CLK_DIV-1 and runs only outside IDLE/DONE.
  - Each wrap toggles `dna_clk_o`.
  - `dna_clk_o` starts low when leaving IDLE, so one port period = 2*CLK_DIV `clk` cycles.
  - All port outputs are registered (glitch-free).
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Port outputs are 0.
  - `start_i` = 1, or the first cycle after reset when READ_ON_RESET = 1, moves to LOAD.
  - On that transition, `dna_valid_o` is cleared and `busy_o` = 1 from the next cycle.
- LOAD:
  - `dna_read_o` = 1 and `dna_shift_o` = 0 for exactly one port period (low phase then high phase).
  - `dna_read_o` is therefore high for 2*CLK_DIV >= 4 cycles, which spans one rising edge of `dna_clk_o`.
  - Moves to SHIFT at the end of the period.
- SHIFT:
  - `dna_read_o` = 0 and `dna_shift_o` = 1.
  - On the `clk` cycle where `dna_clk_o` is driven 0 -> 1, `dna_dout_i` is captured: shift register <= {sr[DNA_WIDTH-2:0], dna_dout_i} and the bit counter increments.
  - After DNA_WIDTH captures, the block completes the current period with `dna_clk_o` back low, then moves to DONE.
  - Exactly DNA_WIDTH port periods are spent in SHIFT.
- DONE (1 cycle):
  - `dna_o` <= shift register; `done_o` = 1; `dna_valid_o` <= 1; `busy_o` = 0 on the next cycle; return to IDLE.
- Latency: a start accepted at edge k gives `busy_o` = 1 from k+1 and `done_o` at cycle k+1+2*CLK_DIV*(DNA_WIDTH+1). With defaults this is k+465.
- `start_i` while `busy_o` = 1 is ignored (not queued).
- A start in the cycle `done_o` is high is also ignored. A start in the following cycle is accepted.
- `dna_o` is held unchanged during a new read until its DONE.
- `dna_dout_i` is assumed stable across the capture cycle: it changes only after a port rising edge, and capture uses the pre-edge value.

Test Plan:
- Reset release with READ_ON_RESET = 1 and a DNA model loaded with 57'h1A5_5A5A_5A5A_5A5A -> `busy_o` rises the next cycle; `done_o` pulses 465 cycles later; `dna_o` = 57'h1A5_5A5A_5A5A_5A5A; `dna_valid_o` = 1.
- Port waveform check with CLK_DIV = 4 -> `dna_read_o` high exactly 8 cycles with one `dna_clk_o` rising edge; 57 rising edges with `dna_shift_o` = 1; no `dna_read_o`/`dna_shift_o` overlap.
- Second `start_i` pulse 100 cycles into a read -> ignored; exactly one `done_o`. A new start after done clears `dna_valid_o`, and old `dna_o` stays held until the new DONE.
- `rst` asserted at cycle 200 of a read -> all outputs 0 asynchronously; no `done_o`. The next start completes normally with the correct ID.
- CLK_DIV = 2, READ_ON_RESET = 0, ID = all-ones then alternating 1/0 -> `done_o` at k+1+4*58 = k+233; `dna_o` bit-exact in both runs, MSB first.
- Start asserted in the `done_o` cycle -> ignored; start one cycle later -> accepted.
